wallace_mul_pipe: RTL and testbench

Parametrised, pipelined Wallace-tree multiplier. Supports WIDTH-bit operands, unsigned and signed (two's-complement) modes, and a valid/ready handshake with full backpressure. It is the registered, throughput-one successor to the team's combinational 32-bit carry-save multiplier. It sits in the datapath between operand-issue logic and the result writeback path.

---
 rtl/wallace_pkg.sv | 53 +++++
 rtl/wallace_mul_pipe_if.sv | 29 ++
 rtl/csa_row.sv | 16 +
 rtl/wallace_mul_pipe.sv | 128 ++++++++++++
 tb/tb_wallace_mul_pipe.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wallace_pkg.sv
// Shared helpers for the pipelined Wallace-tree multiplier.
//   wallace_levels : number of 3:2 levels needed to reduce a row count to 2
//   rows_after     : rows remaining after a given number of levels
//   bw_pp          : one Baugh-Wooley partial-product row, aligned to its weight
package wallace_pkg;

    localparam int NUM_STAGES = 3;
    localparam int MAX_W      = 64;

    function automatic int wallace_levels(int rows);
        int r;
        int l;
        r = rows;
        l = 0;
        while (r > 2) begin
            r = 2 * (r / 3) + r % 3;
            l++;
        end
        return l;
    endfunction

    function automatic int rows_after(int rows, int lvls);
        int r;
        r = rows;
        for (int k = 0; k < lvls; k++) begin
            if (r > 2) r = 2 * (r / 3) + r % 3;
        end
        return r;
    endfunction

    // Row i = a * b_bit shifted by i. In signed mode the terms that involve exactly one
    // operand MSB are inverted; row 0 also carries the constant correction bits at
    // weights w and 2w-1 (those positions are otherwise empty in row 0).
    function automatic logic [2*MAX_W-1:0] bw_pp(logic [MAX_W-1:0] a, logic b_bit, int i,
                                                 int w, logic sgn);
        logic [2*MAX_W-1:0] row;
        logic               pbit;
        row = '0;
        for (int j = 0; j < MAX_W; j++) begin
            if (j < w) begin
                pbit = a[j] & b_bit;
                if (sgn && ((j == w - 1) != (i == w - 1))) pbit = ~pbit;
                row[i + j] = pbit;
            end
        end
        if (sgn && i == 0) begin
            row[w]         = 1'b1;
            row[2 * w - 1] = 1'b1;
        end
        return row;
    endfunction

endpackage

// File: rtl/wallace_mul_pipe_if.sv
// Operand/result handshake bundle for wallace_mul_pipe.
//   in_valid/in_ready, A, B, is_signed, in_tag : operation issue side
//   out_valid/out_ready, C, out_tag            : result side
// master = issuer/consumer, slave = multiplier.
interface wallace_mul_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 is_signed;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   C;
    logic [TAG_W-1:0]     out_tag;

    modport master (
        output in_valid, A, B, is_signed, in_tag, out_ready,
        input  in_ready, out_valid, C, out_tag
    );

    modport slave (
        input  in_valid, A, B, is_signed, in_tag, out_ready,
        output in_ready, out_valid, C, out_tag
    );
endinterface

// File: rtl/csa_row.sv
// N-bit 3:2 carry-save compressor row.
//   a, b, c : three addend rows
//   sum     : bitwise a^b^c
//   carry   : majority(a,b,c) shifted up one place (top carry falls off)
module csa_row #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    output logic [N-1:0] sum,
    output logic [N-1:0] carry
);
    assign sum   = a ^ b ^ c;
    assign carry = ((a & b) | (a & c) | (b & c)) << 1;
endmodule

// File: rtl/wallace_mul_pipe.sv
// Three-stage pipelined Wallace-tree multiplier, unsigned or Baugh-Wooley signed per op.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : wallace_mul_pipe_if slave (operands + tag in, product + tag out)
// S1: partial products + first half of CSA levels; S2: remaining levels to 2 rows;
// S3: final carry-propagate add. All stages advance together when the output is free.
module wallace_mul_pipe
    import wallace_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input logic               clk,
    input logic               rst,
    wallace_mul_pipe_if.slave bus
);
    localparam int PW     = 2 * WIDTH;
    localparam int LEVELS = wallace_levels(WIDTH);
    localparam int SPLIT  = (LEVELS + 1) / 2;

    logic adv;
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    // lvl[k] holds the rows entering level k; lvl[SPLIT] is what S1 registers.
    logic [PW-1:0] lvl [0:LEVELS][0:WIDTH-1];

    logic [PW-1:0]    s1_rows_q [0:WIDTH-1];
    logic             s1_valid_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [PW-1:0]    s2_sum_q;
    logic [PW-1:0]    s2_carry_q;
    logic             s2_valid_q;
    logic [TAG_W-1:0] s2_tag_q;
    logic [PW-1:0]    c_q;
    logic             out_valid_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [PW-1:0]    cpa_sum;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        assign lvl[0][i] = PW'(bw_pp(MAX_W'(bus.A), bus.B[i], i, WIDTH, bus.is_signed));
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int N_IN  = rows_after(WIDTH, k);
        localparam int N_GRP = N_IN / 3;
        localparam int N_OUT = rows_after(WIDTH, k + 1);

        logic [PW-1:0] src [0:N_IN-1];

        // The level right after the S1/S2 boundary reads the pipeline register.
        for (genvar r = 0; r < N_IN; r++) begin : g_src
            if (k == SPLIT) begin : g_reg
                assign src[r] = s1_rows_q[r];
            end else begin : g_comb
                assign src[r] = lvl[k][r];
            end
        end

        for (genvar g = 0; g < N_GRP; g++) begin : g_csa
            csa_row #(.N(PW)) u_csa (
                .a    (src[3*g]),
                .b    (src[3*g+1]),
                .c    (src[3*g+2]),
                .sum  (lvl[k+1][2*g]),
                .carry(lvl[k+1][2*g+1])
            );
        end

        for (genvar r = 0; r < N_IN - 3 * N_GRP; r++) begin : g_pass
            assign lvl[k+1][2*N_GRP+r] = src[3*N_GRP+r];
        end

        for (genvar r = N_OUT; r < WIDTH; r++) begin : g_zero
            assign lvl[k+1][r] = '0;
        end
    end

    // Final add; any carry beyond bit PW-1 is dropped.
    if (WIDTH % 32 == 0) begin : g_cpa_slices
        localparam int NS = PW / 32;
        logic [NS-1:0] cy;
        assign cy[0] = 1'b0;
        for (genvar s = 0; s < NS; s++) begin : g_slice
            if (s == NS - 1) begin : g_top
                assign cpa_sum[32*s +: 32] = s2_sum_q[32*s +: 32] + s2_carry_q[32*s +: 32]
                                           + {31'b0, cy[s]};
            end else begin : g_low
                assign {cy[s+1], cpa_sum[32*s +: 32]} = {1'b0, s2_sum_q[32*s +: 32]}
                                                      + {1'b0, s2_carry_q[32*s +: 32]}
                                                      + {32'b0, cy[s]};
            end
        end
    end else begin : g_cpa_flat
        assign cpa_sum = s2_sum_q + s2_carry_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < WIDTH; r++) s1_rows_q[r] <= '0;
            s1_valid_q  <= 1'b0;
            s1_tag_q    <= '0;
            s2_sum_q    <= '0;
            s2_carry_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_tag_q    <= '0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
        end else if (adv) begin
            // Empty stages still load; only the valid bits matter for them.
            for (int r = 0; r < WIDTH; r++) s1_rows_q[r] <= lvl[SPLIT][r];
            s1_valid_q  <= bus.in_valid;
            s1_tag_q    <= bus.in_tag;
            s2_sum_q    <= lvl[LEVELS][0];
            s2_carry_q  <= lvl[LEVELS][1];
            s2_valid_q  <= s1_valid_q;
            s2_tag_q    <= s1_tag_q;
            c_q         <= cpa_sum;
            out_valid_q <= s2_valid_q;
            out_tag_q   <= s2_tag_q;
        end
    end

    assign bus.C         = c_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Self-checking bench: WIDTH=32 directed/random/backpressure/reset tests, and two WIDTH=8
// instances (unsigned and signed) swept over every operand pair.
module tb_wallace_mul_pipe;

    typedef struct {
        logic [63:0] c;
        logic [3:0]  tag;
    } exp32_t;

    typedef struct {
        logic [15:0] c;
        logic [3:0]  tag;
    } exp8_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    int   nvalid;
    int   vfirst;
    int   vlast;

    exp32_t q32[$];
    exp8_t  q8u[$];
    exp8_t  q8s[$];

    wallace_mul_pipe_if #(.WIDTH(32), .TAG_W(4)) bus32 ();
    wallace_mul_pipe_if #(.WIDTH(8),  .TAG_W(4)) bus8u ();
    wallace_mul_pipe_if #(.WIDTH(8),  .TAG_W(4)) bus8s ();

    wallace_mul_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    wallace_mul_pipe #(.WIDTH(8),  .TAG_W(4)) dut8u (.clk(clk), .rst(rst), .bus(bus8u));
    wallace_mul_pipe #(.WIDTH(8),  .TAG_W(4)) dut8s (.clk(clk), .rst(rst), .bus(bus8s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: extend each operand to the product width by mode, multiply, keep low bits.
    function automatic logic [63:0] ref32(logic [31:0] a, logic [31:0] b, logic sgn);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    function automatic logic [15:0] ref8(logic [7:0] a, logic [7:0] b, logic sgn);
        logic [15:0] ea;
        logic [15:0] eb;
        ea = sgn ? {{8{a[7]}}, a} : {8'b0, a};
        eb = sgn ? {{8{b[7]}}, b} : {8'b0, b};
        return ea * eb;
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hffff_ffff;
            2:       return 32'h0000_0000;
            default: return $urandom();
        endcase
    endfunction

    // Scoreboard for the 32-bit instance: push on accept, pop and compare on take.
    always @(negedge clk) begin
        exp32_t e;
        cyc++;
        if (rst) begin
            q32.delete();
        end else begin
            if (bus32.out_valid) begin
                nvalid++;
                if (vfirst < 0) vfirst = cyc;
                vlast = cyc;
            end
            if (bus32.out_valid && bus32.out_ready) begin
                if (q32.size() == 0) begin
                    check_eq("sb32_extra_result", q32.size(), 1);
                end else begin
                    e = q32.pop_front();
                    check_eq("sb32_c", bus32.C, e.c);
                    check_eq("sb32_tag", bus32.out_tag, e.tag);
                end
            end
            if (bus32.in_valid && bus32.in_ready) begin
                e.c   = ref32(bus32.A, bus32.B, bus32.is_signed);
                e.tag = bus32.in_tag;
                q32.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        exp8_t e;
        if (rst) begin
            q8u.delete();
            q8s.delete();
        end else begin
            if (bus8u.out_valid) begin
                if (q8u.size() == 0) check_eq("sb8u_extra_result", q8u.size(), 1);
                else begin
                    e = q8u.pop_front();
                    check_eq("sb8u_c", bus8u.C, e.c);
                    check_eq("sb8u_tag", bus8u.out_tag, e.tag);
                end
            end
            if (bus8s.out_valid) begin
                if (q8s.size() == 0) check_eq("sb8s_extra_result", q8s.size(), 1);
                else begin
                    e = q8s.pop_front();
                    check_eq("sb8s_c", bus8s.C, e.c);
                    check_eq("sb8s_tag", bus8s.out_tag, e.tag);
                end
            end
            if (bus8u.in_valid && bus8u.in_ready) begin
                e.c = ref8(bus8u.A, bus8u.B, 1'b0);
                e.tag = bus8u.in_tag;
                q8u.push_back(e);
            end
            if (bus8s.in_valid && bus8s.in_ready) begin
                e.c = ref8(bus8s.A, bus8s.B, 1'b1);
                e.tag = bus8s.in_tag;
                q8s.push_back(e);
            end
        end
    end

    // Present one op on an idle pipe, measure cycles until out_valid, check the product.
    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input logic [3:0] tag, input logic [63:0] expc, input string name);
        int lat;
        bus32.A         = a;
        bus32.B         = b;
        bus32.is_signed = sgn;
        bus32.in_tag    = tag;
        bus32.in_valid  = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) bus32.in_valid = 1'b0;
        end while (!bus32.out_valid && lat < 10);
        check_eq({name, "_latency"}, lat, 3);
        check_eq({name, "_c"}, bus32.C, expc);
        check_eq({name, "_tag"}, bus32.out_tag, tag);
    endtask

    initial begin
        logic [31:0] ba [0:2];
        logic [31:0] bb [0:2];
        int          stale;

        checks = 0;
        errors = 0;
        cyc    = 0;
        nvalid = 0;
        vfirst = -1;
        vlast  = -1;
        rst    = 1'b1;
        bus32.in_valid = 1'b0; bus32.A = '0; bus32.B = '0; bus32.is_signed = 1'b0;
        bus32.in_tag = '0; bus32.out_ready = 1'b1;
        bus8u.in_valid = 1'b0; bus8u.A = '0; bus8u.B = '0; bus8u.is_signed = 1'b0;
        bus8u.in_tag = '0; bus8u.out_ready = 1'b1;
        bus8s.in_valid = 1'b0; bus8s.A = '0; bus8s.B = '0; bus8s.is_signed = 1'b1;
        bus8s.in_tag = '0; bus8s.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", bus32.out_valid, 1'b0);
        check_eq("rst_c", bus32.C, 64'h0);
        check_eq("rst_out_tag", bus32.out_tag, 4'h0);
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", bus32.in_ready, 1'b1);
        @(posedge clk);
        #1;

        run_one(32'hffff_ffff, 32'hffff_ffff, 1'b0, 4'h1, 64'hffff_fffe_0000_0001, "u_max");
        run_one(32'hffff_ffff, 32'hffff_ffff, 1'b1, 4'h2, 64'h0000_0000_0000_0001, "s_m1");
        run_one(32'h8000_0000, 32'h8000_0000, 1'b1, 4'h3, 64'h4000_0000_0000_0000, "s_min");
        run_one(32'h8000_0000, 32'h0000_0001, 1'b1, 4'h4, 64'hffff_ffff_8000_0000, "s_minx1");
        repeat (4) @(posedge clk);
        #1;

        // Streaming: 100 back-to-back random ops, mixed modes, incrementing tags.
        nvalid = 0;
        vfirst = -1;
        for (int i = 0; i < 100; i++) begin
            bus32.A         = pick32();
            bus32.B         = pick32();
            bus32.is_signed = 1'($urandom_range(0, 1));
            bus32.in_tag    = 4'(i);
            bus32.in_valid  = 1'b1;
            @(posedge clk);
            #1;
        end
        bus32.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_eq("stream_count", nvalid, 100);
        check_eq("stream_no_gaps", vlast - vfirst + 1, 100);
        check_eq("stream_drained", q32.size(), 0);

        // Backpressure: three ops in flight, then hold out_ready low for 5 cycles.
        for (int i = 0; i < 3; i++) begin
            ba[i] = pick32();
            bb[i] = pick32();
            bus32.A         = ba[i];
            bus32.B         = bb[i];
            bus32.is_signed = 1'(i == 1);
            bus32.in_tag    = 4'(8 + i);
            bus32.in_valid  = 1'b1;
            @(posedge clk);
            #1;
        end
        check_eq("bp_first_valid", bus32.out_valid, 1'b1);
        bus32.out_ready = 1'b0;
        bus32.A         = 32'h1234_5678;
        bus32.B         = 32'h9abc_def0;
        bus32.in_tag    = 4'hf;
        bus32.in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_in_ready", bus32.in_ready, 1'b0);
            check_eq("bp_out_valid", bus32.out_valid, 1'b1);
            check_eq("bp_c_frozen", bus32.C, ref32(ba[0], bb[0], 1'b0));
            check_eq("bp_tag_frozen", bus32.out_tag, 4'h8);
            @(posedge clk);
            #1;
        end
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("bp_drained", q32.size(), 0);
        check_eq("bp_idle", bus32.out_valid, 1'b0);

        // Reset mid-flight: two ops accepted, reset on the following cycle.
        for (int i = 0; i < 2; i++) begin
            bus32.A         = pick32() | 32'h1;
            bus32.B         = pick32() | 32'h1;
            bus32.is_signed = 1'b0;
            bus32.in_tag    = 4'(5 + i);
            bus32.in_valid  = 1'b1;
            @(posedge clk);
            #1;
        end
        bus32.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_out_valid", bus32.out_valid, 1'b0);
        check_eq("mid_rst_c", bus32.C, 64'h0);
        check_eq("mid_rst_tag", bus32.out_tag, 4'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus32.out_valid) stale++;
        end
        check_eq("mid_rst_no_stale", stale, 0);
        check_eq("mid_rst_in_ready", bus32.in_ready, 1'b1);

        // WIDTH=8: every operand pair, unsigned and signed instances side by side.
        for (int i = 0; i < 65536; i++) begin
            bus8u.A = 8'(i >> 8);
            bus8u.B = 8'(i);
            bus8u.in_tag = 4'(i);
            bus8u.in_valid = 1'b1;
            bus8s.A = 8'(i >> 8);
            bus8s.B = 8'(i);
            bus8s.in_tag = 4'(i + 3);
            bus8s.in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bus8u.in_valid = 1'b0;
        bus8s.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_eq("w8u_drained", q8u.size(), 0);
        check_eq("w8s_drained", q8s.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
